serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes `a - b - b_in` one bit per clock, LSB first, through a single 1-bit full-subtract cell with a registered borrow. It sits directly upstream of the 1-bit subtract cell: it owns operand shifting, borrow storage and sequencing, and feeds the cell one bit pair plus borrow each cycle. It is the area-lean alternative to a ripple chain of full subtractors, used where WIDTH-cycle latency is acceptable.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_if.sv | 31 +++
 rtl/serial_subtractor_fs_cell.sv | 15 +
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : FSM state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the bit-serial subtractor.
//   start, a, b, b_in        : request side (driven by the master)
//   busy, done, diff, b_out,
//   ovf                      : status/result side (driven by the slave)
// Handshake: a request is accepted on a rising edge where start=1 and the
// subtractor is in IDLE or DONE; busy is high while bits are processed;
// done is a single-cycle strobe and diff/b_out/ovf stay valid from the done
// cycle until the next accepted start. There is no back-pressure.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out, ovf
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out, ovf
  );
endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - b_in, one bit per clock,
// LSB first, through a single fs_cell with a registered borrow.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : serial_subtractor_if slave (start/a/b/b_in in,
//             busy/done/diff/b_out/ovf out)
//   o_state : current FSM state (debug visibility)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_if.slave    bus,
  output state_t                o_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CNT_W-1:0] r_count;
  // Operand MSBs are kept aside because the shift registers have lost them
  // by the time the overflow flag is computed on the last bit.
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_b_out;
  logic             r_ovf;

  logic             w_cell_d;
  logic             w_cell_bout;

  fs_cell u_cell (
    .x    (r_a_sr[0]),
    .y    (r_b_sr[0]),
    .bin  (r_borrow),
    .d    (w_cell_d),
    .bout (w_cell_bout)
  );

  assign w_last = (r_state == S_RUN) && (r_count == LAST_BIT);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state; start is only looked at in IDLE and DONE
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand load on accept, one bit per edge while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_b_out  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= bus.a;
      r_b_sr   <= bus.b;
      r_borrow <= bus.b_in;
      r_count  <= '0;
      r_a_msb  <= bus.a[WIDTH-1];
      r_b_msb  <= bus.b[WIDTH-1];
    end else if (r_state == S_RUN) begin
      // Difference bits enter at the MSB; after WIDTH shifts bit 0 is at LSB.
      r_diff   <= {w_cell_d, r_diff[WIDTH-1:1]};
      r_borrow <= w_cell_bout;
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      if (w_last) begin
        // Counter is left at WIDTH-1 so it never wraps.
        r_b_out <= w_cell_bout;
        // w_cell_d is the new diff MSB being shifted in on this edge.
        r_ovf   <= (r_a_msb ^ r_b_msb) & (w_cell_d ^ r_a_msb);
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = (r_state == S_DONE);
  assign bus.diff  = r_diff;
  assign bus.b_out = r_b_out;
  assign bus.ovf   = r_ovf;
  assign o_state   = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors with hand-computed results on
// a WIDTH=8 instance plus a reference-model sweep at WIDTH=8 and WIDTH=16.
// Expected results are queued when a request is issued; a monitor pops and
// compares whenever done is seen.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();
  state_t state8;
  state_t state16;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus8),
    .o_state (state8)
  );

  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus16),
    .o_state (state16)
  );

  // ---------------- scoreboard ----------------
  // Packed as {ovf, b_out, diff[15:0]}; 8-bit results are zero-extended.
  logic [17:0] exp8_q[$];
  logic [17:0] exp16_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [17:0] pk(input logic [15:0] d, input logic bo, input logic ov);
    return {ov, bo, d};
  endfunction

  // Reference: full-width subtraction, borrow read from the extra bit.
  function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic bin);
    logic [16:0] full;
    logic [15:0] d;
    logic        ov;
    full = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    d    = full[15:0] & 16'((32'd1 << w) - 1);
    ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    return pk(d, full[16], ov);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [17:0] exp;
    forever begin
      @(negedge clk);
      if (bus8.done) begin
        if (exp8_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL done8_unexpected: done=1 with no expected result queued (t=%0t)", $time);
        end else begin
          exp = exp8_q.pop_front();
          chk("result8", {14'd0, bus8.ovf, bus8.b_out, 8'd0, bus8.diff}, {14'd0, exp});
        end
      end
      if (bus16.done) begin
        if (exp16_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL done16_unexpected: done=1 with no expected result queued (t=%0t)", $time);
        end else begin
          exp = exp16_q.pop_front();
          chk("result16", {14'd0, bus16.ovf, bus16.b_out, bus16.diff}, {14'd0, exp});
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulse start for one cycle; returns 1 time unit after the accepting edge.
  task automatic issue(input bit is16, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input bit push, input logic [17:0] exp);
    @(posedge clk);
    #1;
    if (is16) begin
      bus16.a = a; bus16.b = b; bus16.b_in = bin; bus16.start = 1'b1;
      if (push) exp16_q.push_back(exp);
    end else begin
      bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.b_in = bin; bus8.start = 1'b1;
      if (push) exp8_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
  endtask

  // Count negedge samples until done (bounded); check latency and busy span.
  task automatic wait_done(input bit is16, input int exp_lat);
    int   cyc;
    int   nb;
    logic dn;
    cyc = 0;
    nb  = 0;
    do begin
      @(negedge clk);
      cyc++;
      dn = is16 ? bus16.done : bus8.done;
      if (is16 ? bus16.busy : bus8.busy) nb++;
    end while (!dn && cyc < 60);
    chk(is16 ? "latency16" : "latency8", cyc, exp_lat);
    chk(is16 ? "busy_cycles16" : "busy_cycles8", nb, exp_lat - 1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] d, input logic bo, input logic ov);
    issue(1'b0, {8'd0, a}, {8'd0, b}, bin, 1'b1, pk({8'd0, d}, bo, ov));
    wait_done(1'b0, 9);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.b_in = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.b_in = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus8.busy, 0);
    chk("rst_done", bus8.done, 0);
    chk("rst_diff", bus8.diff, 0);
    chk("rst_bout_ovf", {bus8.b_out, bus8.ovf}, 0);
    chk("rst_state", 32'(state8), 32'(S_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors
    run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // start held through RUN with changing operands, then back-to-back
    @(posedge clk);
    #1;
    bus8.a = 8'h33; bus8.b = 8'h11; bus8.b_in = 1'b0; bus8.start = 1'b1;
    exp8_q.push_back(pk(16'h0022, 1'b0, 1'b0));
    @(posedge clk);                         // accepting edge
    for (int i = 0; i < 8; i++) begin
      #1;
      bus8.a = 8'($urandom_range(0, 255));
      bus8.b = 8'($urandom_range(0, 255));
      bus8.b_in = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    #1;
    bus8.a = 8'h44; bus8.b = 8'h22; bus8.b_in = 1'b1;
    exp8_q.push_back(pk(16'h0021, 1'b0, 1'b0));
    @(negedge clk);
    chk("hold_done", bus8.done, 1);
    chk("hold_state", 32'(state8), 32'(S_DONE));
    @(posedge clk);                         // back-to-back accept from DONE
    #1 bus8.start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", bus8.busy, 1);
    wait_done(1'b0, 8);

    // Reset at the 4th RUN edge aborts the operation
    issue(1'b0, 16'h0077, 16'h0011, 1'b0, 1'b0, '0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", bus8.busy, 0);
    chk("abort_done", bus8.done, 0);
    chk("abort_diff", bus8.diff, 0);
    chk("abort_bout_ovf", {bus8.b_out, bus8.ovf}, 0);
    chk("abort_state", 32'(state8), 32'(S_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_idle", 32'(state8), 32'(S_IDLE));
    run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    // Reference-model sweep
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      ra   = 16'($urandom_range(0, 255));
      rb   = 16'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      issue(1'b0, ra, rb, rbin, 1'b1, model(8, ra, rb, rbin));
      wait_done(1'b0, 9);
    end
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      ra   = 16'($urandom_range(0, 65535));
      rb   = 16'($urandom_range(0, 65535));
      rbin = 1'($urandom_range(0, 1));
      issue(1'b1, ra, rb, rbin, 1'b1, model(16, ra, rb, rbin));
      wait_done(1'b1, 17);
    end

    // ---------------- final report ----------------
    repeat (4) @(negedge clk);
    chk("queue8_drained", exp8_q.size(), 0);
    chk("queue16_drained", exp16_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
